row_maxpool_32_16bit: RTL and testbench

//  Vertical max-pooling stage that sits directly downstream of the 16-bit activation

---
 rtl/row_maxpool_32_16bit.sv | 94 +++++++++
 tb/tb_row_maxpool_32_16bit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_maxpool_32_16bit.sv
// Per-lane signed max over groups of 1/2/4 consecutive rows, with a flush of any partial group at end of stream.
// Pooled row is registered 1 cycle after the group's last row; there is no backpressure, and enable_pool=0 gives a 1-cycle bypass.
module row_maxpool_32_16bit #(
  parameter int DWIDTH      = 16,
  parameter int DESIGN_SIZE = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable_pool,
  input  logic [1:0]                    pool_window,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic                          done_pool
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                    state;
  logic [1:0]                    cnt;
  logic [1:0]                    win_q;
  logic [DESIGN_SIZE*DWIDTH-1:0] acc;
  logic [DESIGN_SIZE*DWIDTH-1:0] max_row;
  logic [DESIGN_SIZE*DWIDTH-1:0] acc_next;
  logic [1:0]                    win_sel;
  logic [1:0]                    last_idx;

  for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
    assign max_row[i*DWIDTH +: DWIDTH] =
      ($signed(acc[i*DWIDTH +: DWIDTH]) > $signed(inp_data[i*DWIDTH +: DWIDTH])) ?
      acc[i*DWIDTH +: DWIDTH] : inp_data[i*DWIDTH +: DWIDTH];
  end

  // The first row of a stream uses the live window; later rows use the latched one.
  always_comb begin
    win_sel  = (state == IDLE) ? pool_window : win_q;
    last_idx = (win_sel == 2'd0) ? 2'd0 : ((win_sel == 2'd1) ? 2'd1 : 2'd3);
    acc_next = (cnt == 2'd0) ? inp_data : max_row;
  end

  assign done_pool = !enable_pool || (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data           <= '0;
      out_data_available <= 1'b0;
      acc                <= '0;
      cnt                <= 2'd0;
      win_q              <= 2'd0;
      state              <= IDLE;
    end else if (!enable_pool) begin
      out_data           <= inp_data;
      out_data_available <= in_data_available;
      cnt                <= 2'd0;
      state              <= IDLE;
    end else begin
      out_data_available <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (in_data_available) begin
            if (state == IDLE) win_q <= pool_window;
            acc <= acc_next;
            if (cnt == last_idx) begin
              out_data           <= acc_next;
              out_data_available <= 1'b1;
              cnt                <= 2'd0;
            end else begin
              cnt <= cnt + 2'd1;
            end
            state <= ACCUM;
          end else if (state == ACCUM) begin
            // Partial group is emitted on entry so it is valid while in FLUSH.
            if (cnt != 2'd0) begin
              out_data           <= acc;
              out_data_available <= 1'b1;
              cnt                <= 2'd0;
              state              <= FLUSH;
            end else begin
              state <= DONE;
            end
          end
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_maxpool_32_16bit.sv
// Bench for row_maxpool_32_16bit: scoreboarded row streams over each window size, signed edges,
// flush, bypass and mid-stream reset.
module tb_row_maxpool_32_16bit;
  localparam int DW = 16;
  localparam int DS = 32;
  localparam int W  = DW * DS;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enable_pool;
  logic [1:0]   pool_window;
  logic         in_data_available;
  logic [W-1:0] inp_data;
  logic [W-1:0] out_data;
  logic         out_data_available;
  logic         done_pool;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [W-1:0] data;
    int           at;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] rows_mem[8];

  row_maxpool_32_16bit dut (
    .clk                (clk),
    .resetn             (resetn),
    .enable_pool        (enable_pool),
    .pool_window        (pool_window),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < DS; i++)
      r[i*DW +: DW] = ($signed(a[i*DW +: DW]) > $signed(b[i*DW +: DW])) ? a[i*DW +: DW] : b[i*DW +: DW];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < DS; i++) r[i*DW +: DW] = 16'($urandom_range(0, 65535));
    return r;
  endfunction

  // Drives rows_mem[0..nrows-1] as one stream (window changed after row 0 to prove it is
  // latched), pushes each expected pooled row with its due edge, and checks every cycle.
  task automatic play_stream(input string tag, input logic [1:0] wsel, input int nrows);
    int           win;
    int           k;
    int           done_at;
    logic [W-1:0] macc;
    logic         exp_pulse;
    exp_t         e;
    win     = (wsel == 2'b00) ? 1 : ((wsel == 2'b01) ? 2 : 4);
    k       = 0;
    macc    = '0;
    done_at = -1;
    exp_q.delete();
    got_q.delete();
    for (int c = 0; c < nrows + 5; c++) begin
      if (c < nrows) begin
        in_data_available = 1'b1;
        inp_data          = rows_mem[c];
        pool_window       = (c == 0) ? wsel : ~wsel;
        macc = (k == 0) ? rows_mem[c] : vmax(macc, rows_mem[c]);
        k++;
        if (k == win) begin
          e.data = macc;
          e.at   = edge_cnt + 1;
          exp_q.push_back(e);
          k = 0;
        end
      end else begin
        in_data_available = 1'b0;
        inp_data          = rand_row();
        pool_window       = ~wsel;
        if (c == nrows) begin
          if (k != 0) begin
            e.data = macc;
            e.at   = edge_cnt + 1;
            exp_q.push_back(e);
            done_at = edge_cnt + 2;
          end else begin
            done_at = edge_cnt + 1;
          end
        end
      end
      @(posedge clk);
      #1;
      exp_pulse = (exp_q.size() > 0) && (exp_q[0].at == edge_cnt);
      n_checks++;
      if (out_data_available !== exp_pulse)
        $display("FAIL %s pulse at edge %0d: got %b want %b", tag, edge_cnt, out_data_available, exp_pulse);
      else n_pass++;
      if (out_data_available === 1'b1) got_q.push_back(out_data);
      if (exp_pulse) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_data !== e.data)
          $display("FAIL %s data at edge %0d: got %h want %h", tag, edge_cnt, out_data, e.data);
        else n_pass++;
      end
      n_checks++;
      if (done_pool !== (edge_cnt == done_at))
        $display("FAIL %s done_pool at edge %0d: got %b want %b", tag, edge_cnt, done_pool, (edge_cnt == done_at));
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s missing pulses: %0d left", tag, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn            = 1'b0;
    enable_pool       = 1'b1;
    pool_window       = 2'b00;
    in_data_available = 1'b0;
    inp_data          = '0;
    #2;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset out_data: got %h want 0", out_data);
    else n_pass++;
    n_checks++;
    if (out_data_available !== 1'b0) $display("FAIL reset out_data_available: got %b want 0", out_data_available);
    else n_pass++;
    n_checks++;
    if (done_pool !== 1'b0) $display("FAIL reset done_pool: got %b want 0", done_pool);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_win2_basic();
    rows_mem[0] = rand_row();
    rows_mem[1] = rand_row();
    rows_mem[0][15:0] = 16'hFFFB;
    rows_mem[1][15:0] = 16'h0003;
    play_stream("win2", 2'b01, 2);
    n_checks++;
    if (got_q.size() != 1) $display("FAIL win2 pulse count: got %0d want 1", got_q.size());
    else if (got_q[0][15:0] !== 16'h0003) $display("FAIL win2 lane0: got %h want 0003", got_q[0][15:0]);
    else n_pass++;
  endtask

  task automatic test_signed_edges();
    rows_mem[0] = rand_row();
    rows_mem[1] = rand_row();
    rows_mem[0][15:0]  = 16'h8000; rows_mem[1][15:0]  = 16'h7FFF;
    rows_mem[0][31:16] = 16'hFFFF; rows_mem[1][31:16] = 16'h8000;
    rows_mem[0][47:32] = 16'h8000; rows_mem[1][47:32] = 16'h8000;
    play_stream("signed", 2'b01, 2);
    n_checks++;
    if (got_q.size() != 1) $display("FAIL signed pulse count: got %0d want 1", got_q.size());
    else if (got_q[0][47:0] !== 48'h8000_FFFF_7FFF)
      $display("FAIL signed lanes2..0: got %h want 8000ffff7fff", got_q[0][47:0]);
    else n_pass++;
  endtask

  task automatic test_win4_flush();
    logic [15:0] lane0[6];
    lane0 = '{16'd1, 16'd9, 16'd2, 16'd4, 16'd7, 16'hFFFF};
    for (int i = 0; i < 6; i++) begin
      rows_mem[i] = rand_row();
      rows_mem[i][15:0] = lane0[i];
    end
    play_stream("win4", 2'b11, 6);
    n_checks++;
    if (got_q.size() != 2) $display("FAIL win4 pulse count: got %0d want 2", got_q.size());
    else if (got_q[0][15:0] !== 16'd9 || got_q[1][15:0] !== 16'd7)
      $display("FAIL win4 lane0: got %h,%h want 0009,0007", got_q[0][15:0], got_q[1][15:0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) rows_mem[i] = rand_row();
    play_stream("win1", 2'b00, 3);
    n_checks++;
    if (got_q.size() != 3) $display("FAIL win1 pulse count: got %0d want 3", got_q.size());
    else if (got_q[0] !== rows_mem[0] || got_q[1] !== rows_mem[1] || got_q[2] !== rows_mem[2])
      $display("FAIL win1 passthrough: got %h want %h", got_q[2], rows_mem[2]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [W-1:0] prev_d;
    logic         prev_v;
    enable_pool = 1'b1;
    pool_window = 2'b10;
    for (int i = 0; i < 2; i++) begin
      in_data_available = 1'b1;
      inp_data          = rand_row();
      @(posedge clk);
      #1;
    end
    enable_pool = 1'b0;
    #1;
    n_checks++;
    if (done_pool !== 1'b1) $display("FAIL bypass done_pool comb: got %b want 1", done_pool);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      in_data_available = 1'($urandom_range(0, 1));
      inp_data          = rand_row();
      prev_d            = inp_data;
      prev_v            = in_data_available;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_data !== prev_d || out_data_available !== prev_v || done_pool !== 1'b1)
        $display("FAIL bypass cycle %0d: got v=%b d=%h done=%b want v=%b d=%h done=1",
                 c, out_data_available, out_data, done_pool, prev_v, prev_d);
      else n_pass++;
    end
    enable_pool       = 1'b1;
    in_data_available = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_data_available !== 1'b0 || done_pool !== 1'b0)
        $display("FAIL bypass discard %0d: got v=%b done=%b want 0,0", c, out_data_available, done_pool);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    enable_pool = 1'b1;
    pool_window = 2'b01;
    for (int i = 0; i < 2; i++) begin
      in_data_available = 1'b1;
      inp_data          = rand_row();
      inp_data[15:0]    = 16'h1234;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (out_data_available !== 1'b1 || out_data[15:0] !== 16'h1234)
      $display("FAIL rst pre-pulse: got v=%b lane0=%h want 1,1234", out_data_available, out_data[15:0]);
    else n_pass++;
    in_data_available = 1'b0;
    resetn            = 1'b0;
    #1;
    n_checks++;
    if (out_data !== '0 || out_data_available !== 1'b0 || done_pool !== 1'b0)
      $display("FAIL rst async clear: got v=%b done=%b d=%h want 0", out_data_available, done_pool, out_data);
    else n_pass++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done_pool !== 1'b0 || out_data_available !== 1'b0)
        $display("FAIL rst no flush %0d: got v=%b done=%b want 0,0", c, out_data_available, done_pool);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < DS; l++) rows_mem[i][l*DW +: DW] = 16'(-$urandom_range(1, 1000));
    play_stream("post_rst", 2'b01, 4);
    n_checks++;
    if (got_q.size() != 2) $display("FAIL post_rst pulse count: got %0d want 2", got_q.size());
    else if (!got_q[0][15] || !got_q[1][15])
      $display("FAIL post_rst stale acc: got lane0 %h,%h want negative", got_q[0][15:0], got_q[1][15:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_win2_basic();
    test_signed_edges();
    test_win4_flush();
    test_back_to_back();
    test_bypass();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
